// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and the fetch state encoding.
package fetch_sequencer_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned INST_W = 16;
  localparam int unsigned OPC_W  = 4;

  localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OPC_W-1:0] OP_ALU    = 4'h1;
  localparam logic [OPC_W-1:0] OP_LOAD   = 4'h2;
  localparam logic [OPC_W-1:0] OP_STORE  = 4'h3;
  localparam logic [OPC_W-1:0] OP_BRANCH = 4'h4;
  localparam logic [OPC_W-1:0] OP_JUMP   = 4'h5;
  localparam logic [OPC_W-1:0] OP_HALT   = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read port plus the valid/ready link from fetch to decode.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [INST_W-1:0] mem_inst;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              dec_ready;

  modport master (
    output mem_addr, mem_en, inst, inst_pc, inst_valid,
    input  mem_inst, dec_ready
  );

  modport slave (
    input  mem_addr, mem_en, inst, inst_pc, inst_valid,
    output mem_inst, dec_ready
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and instruction-memory sequencer feeding decode over valid/ready.
// The memory output register doubles as the fetch buffer: stalls simply stop issuing.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [OPC_W-1:0]  HALT_OPCODE = OP_HALT,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_pc,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  fetch_sequencer_if.master bus,
  output logic              o_halted,
  output logic              o_busy
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pend_pc_q;
  logic              pend_q;

  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic              inst_valid;
  logic              halt_accept;

  // A redirect squashes the word on the memory output in the same cycle.
  assign inst_valid  = pend_q && !i_redirect && (state_q == FETCH);
  assign halt_accept = inst_valid && bus.dec_ready && (opcode_of(bus.mem_inst) == HALT_OPCODE);

  always_comb begin
    issue      = 1'b0;
    issue_addr = pc_q;
    if (!i_reset) begin
      case (state_q)
        IDLE: begin
          issue = i_start;
          if (i_start) issue_addr = i_start_pc;
        end
        FETCH: begin
          issue = (!pend_q || bus.dec_ready || i_redirect) && !halt_accept;
          if (i_redirect) issue_addr = i_redirect_pc;
        end
        HALTED: begin
          issue = i_start || i_redirect;
          if (i_redirect)   issue_addr = i_redirect_pc;
          else if (i_start) issue_addr = i_start_pc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      o_halted  <= 1'b0;
      o_busy    <= 1'b0;
    end else if (issue) begin
      state_q   <= FETCH;
      pend_q    <= 1'b1;
      pend_pc_q <= issue_addr;
      pc_q      <= issue_addr + 1'b1;
      o_halted  <= 1'b0;
      o_busy    <= 1'b1;
    end else if (halt_accept) begin
      state_q   <= HALTED;
      pend_q    <= 1'b0;
      pc_q      <= pend_pc_q + 1'b1;
      o_halted  <= 1'b1;
      o_busy    <= 1'b0;
    end
  end

  assign bus.mem_en     = issue;
  assign bus.mem_addr   = issue_addr;
  assign bus.inst       = bus.mem_inst;
  assign bus.inst_pc    = pend_pc_q;
  assign bus.inst_valid = inst_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// run compared every cycle against a presented-word model of the fetch stream.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] spc;
  logic        redirect;
  logic [11:0] rpc;
  logic        ready;
  logic        halted;
  logic        busy;
  logic [15:0] mem [4096];
  logic [15:0] mem_q = 16'h0;
  int          n_checks = 0;
  int          n_pass   = 0;

  fetch_sequencer_if bus ();

  assign bus.dec_ready = ready;
  assign bus.mem_inst  = mem_q;

  fetch_sequencer dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_start_pc    (spc),
    .i_redirect    (redirect),
    .i_redirect_pc (rpc),
    .bus           (bus),
    .o_halted      (halted),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  // Synchronous memory: one-cycle latency, output held while enable is low.
  always @(posedge clk) if (bus.mem_en) mem_q <= mem[bus.mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: while running, one word is always on offer at m_pc; decode consumes it or
  // a redirect replaces it. An issued address is the word on offer next cycle.
  logic        m_active = 1'b0;
  logic        m_halted = 1'b0;
  logic [11:0] m_pc     = 12'h0;

  typedef struct packed {
    logic        valid;
    logic        en;
    logic        hacc;
    logic [11:0] next;
  } exp_t;

  function automatic exp_t model_eval();
    exp_t e;
    e.valid = m_active && !redirect;
    e.hacc  = e.valid && ready && (mem[m_pc][15:12] == 4'hF);
    if (m_active) begin
      e.en   = (ready || redirect) && !e.hacc;
      e.next = redirect ? rpc : m_pc + 12'd1;
    end else begin
      e.en   = start || (m_halted && redirect);
      e.next = (m_halted && redirect) ? rpc : spc;
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_halted <= 1'b0;
      m_pc     <= 12'h0;
    end else begin : upd
      exp_t e;
      e = model_eval();
      if (e.en) begin
        m_active <= 1'b1;
        m_halted <= 1'b0;
        m_pc     <= e.next;
      end else if (e.hacc) begin
        m_active <= 1'b0;
        m_halted <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin : cmp
      exp_t e;
      e = model_eval();
      check("m_busy",   32'(busy),           32'(m_active));
      check("m_halted", 32'(halted),         32'(m_halted));
      check("m_valid",  32'(bus.inst_valid), 32'(e.valid));
      check("m_mem_en", 32'(bus.mem_en),     32'(e.en));
      if (e.en) check("m_mem_addr", 32'(bus.mem_addr), 32'(e.next));
      if (e.valid) begin
        check("m_inst_pc", 32'(bus.inst_pc), 32'(m_pc));
        check("m_inst",    32'(bus.inst),    32'(mem[m_pc]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'hE;
      if (a >= 12'h200 && a < 12'hFF0 && $urandom_range(0, 23) == 0) w[15:12] = 4'hF;
      mem[a] = w;
    end
    mem[12'h004] = 16'hF000;
    mem[12'h103] = 16'hF123;

    rst = 1'b1; start = 1'b0; spc = '0; redirect = 1'b0; rpc = '0; ready = 1'b1;
    #12;
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_valid",  32'(bus.inst_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_addr",   32'(bus.mem_addr), 32'h000);
    @(posedge clk); #1 rst = 1'b0;

    // Start at 0 with ready high.
    tick(); start = 1'b1; spc = 12'h000; #1;
    check("start_en", 32'(bus.mem_en), 32'd1);
    check("start_addr", 32'(bus.mem_addr), 32'h000);
    check("start_valid", 32'(bus.inst_valid), 32'd0);
    tick(); start = 1'b0; #1;
    check("seq_addr1", 32'(bus.mem_addr), 32'h001);
    check("seq_pc0", 32'(bus.inst_pc), 32'h000);
    check("seq_valid0", 32'(bus.inst_valid), 32'd1);
    tick(); #1;
    check("seq_addr2", 32'(bus.mem_addr), 32'h002);
    check("seq_pc1", 32'(bus.inst_pc), 32'h001);

    // Three-cycle stall on 0x002.
    tick(); ready = 1'b0; #1;
    check("stall_pc", 32'(bus.inst_pc), 32'h002);
    check("stall_en", 32'(bus.mem_en), 32'd0);
    repeat (2) begin
      tick(); #1;
      check("stall_hold_en", 32'(bus.mem_en), 32'd0);
      check("stall_hold_pc", 32'(bus.inst_pc), 32'h002);
      check("stall_hold_inst", 32'(bus.inst), 32'(mem[2]));
    end
    tick(); ready = 1'b1; #1;
    check("resume_addr", 32'(bus.mem_addr), 32'h003);
    tick(); #1;
    check("resume_pc", 32'(bus.inst_pc), 32'h003);

    // HALT word at 0x004.
    tick(); #1;
    check("halt_inst", 32'(bus.inst), 32'hF000);
    check("halt_accept_en", 32'(bus.mem_en), 32'd0);
    tick(); #1;
    check("halted", 32'(halted), 32'd1);
    check("halted_en", 32'(bus.mem_en), 32'd0);
    check("halted_valid", 32'(bus.inst_valid), 32'd0);
    start = 1'b1; spc = 12'h010; #1;
    check("restart_addr", 32'(bus.mem_addr), 32'h010);
    tick(); start = 1'b0; #1;
    check("restart_halted", 32'(halted), 32'd0);
    check("restart_pc", 32'(bus.inst_pc), 32'h010);

    // Redirect to 0x005, then redirect away from 0x005 to 0x100.
    redirect = 1'b1; rpc = 12'h005; #1;
    check("redir1_valid", 32'(bus.inst_valid), 32'd0);
    tick(); redirect = 1'b0; #1;
    check("at5_pc", 32'(bus.inst_pc), 32'h005);
    redirect = 1'b1; rpc = 12'h100; #1;
    check("redir2_valid", 32'(bus.inst_valid), 32'd0);
    check("redir2_addr", 32'(bus.mem_addr), 32'h100);
    tick(); redirect = 1'b0; #1;
    check("redir2_pc", 32'(bus.inst_pc), 32'h100);
    tick(); #1;
    check("redir2_pc1", 32'(bus.inst_pc), 32'h101);
    repeat (3) tick();
    #1;
    check("halt2", 32'(halted), 32'd1);

    // Wrap-around from 0xFFE.
    start = 1'b1; spc = 12'hFFE;
    tick(); start = 1'b0; #1;
    check("wrap_pc0", 32'(bus.inst_pc), 32'hFFE);
    tick(); #1;
    check("wrap_pc1", 32'(bus.inst_pc), 32'hFFF);
    tick(); #1;
    check("wrap_pc2", 32'(bus.inst_pc), 32'h000);

    // Asynchronous reset while stalled on a pending word.
    tick(); ready = 1'b0; #1;
    check("prereset_valid", 32'(bus.inst_valid), 32'd1);
    rst = 1'b1; #1;
    check("areset_en", 32'(bus.mem_en), 32'd0);
    check("areset_valid", 32'(bus.inst_valid), 32'd0);
    check("areset_busy", 32'(busy), 32'd0);
    check("areset_addr", 32'(bus.mem_addr), 32'h000);
    tick(); rst = 1'b0; ready = 1'b1;
    redirect = 1'b1; rpc = 12'h200; #1;
    check("idle_redirect_en", 32'(bus.mem_en), 32'd0);
    tick(); redirect = 1'b0;
    repeat (2) begin
      tick(); #1;
      check("idle_en", 32'(bus.mem_en), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      tick();
      ready    = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 15) == 0);
      spc      = 12'($urandom);
      redirect = ($urandom_range(0, 23) == 0);
      rpc      = 12'($urandom);
    end
    tick();
    start = 1'b0; redirect = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
